wino_tile_feeder: RTL
=====================

# wino_tile_feeder

Upstream feeder for the Winograd F(5,4) convolution core `wc`. It accepts a serial stream of signed 10-bit samples with a valid/ready handshake, one row at a time, and builds overlapping 8-sample input tiles: stride 5, overlap 3. Each tile is presented on the core's packed 80-bit `D` input together with framing sidebands. A row tail that does not fill a tile is zero-padded into a final tile. The downstream consumer uses `d_nvalid` to discard the padded outputs of `Z`.

## Interface
- `DW`, 10, sample width (signed two's complement)
- `TILE`, 8, samples per tile (fixed for F(5,4))
- `STEP`, 5, new samples per tile after the first; overlap is `TILE-STEP` = 3
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `s_valid` input 1: input sample valid.
- `s_ready` output 1: block can accept a sample.
- `s_data` input DW: input sample.
- `s_last` input 1: this sample is the last of the row.
- `D` output TILE*DW: tile to `wc`. Oldest sample d0 sits in `[79:70]`, d7 in `[9:0]`. Registered and held between tiles.
- `d_valid` output 1: one-cycle pulse when `D` takes a new tile.
- `d_first` output 1: qualified by `d_valid`; first tile of the row.
- `d_last` output 1: qualified by `d_valid`; last tile of the row.
- `d_nvalid` output 3: qualified by `d_valid`; number of meaningful `Z` outputs, 1..5.
- `row_drop` output 1: one-cycle pulse when a row with 3 or fewer samples is discarded.

## Operation
- Window: 8×DW shift register. An accepted sample shifts in at the LSB slot and older samples move toward the MSB.
- Handshake: a sample is accepted when `s_valid && s_ready` at a rising edge. `s_data` and `s_last` are ignored otherwise.
- `cnt` (0..8) counts samples in the window that have not yet been emitted as new data.
- FSM states:
  - FILL (first tile of row)
    - Accept until `cnt`=8, then emit the tile with `d_first`=1 and go to RUN.
    - `s_last` with `cnt`<8 goes to FLUSH.
  - RUN
    - Accept until 5 new samples, then emit the tile with `d_first`=0.
    - `s_last` on the completing sample: emit with `d_last`=1 and go to FILL.
    - `s_last` earlier goes to FLUSH.
  - FLUSH (one cycle, `s_ready`=0)
    - Shift in the required zeros in a single cycle: `8-n` zeros for a short first tile of n samples, `5-k` zeros after k new samples in RUN.
    - Emit with `d_last`=1, then go to FILL with `cnt`=0.
- `d_nvalid` rules:
  - 5 for every full tile.
  - k for a padded RUN tail.
  - n-3 for a short row with n in 4..7.
- Short rows with n ≤ 3: in FLUSH, no tile is emitted, `D` is unchanged, `row_drop` pulses and the FSM returns to FILL.
- A full tile completed by an `s_last` sample never enters FLUSH.
- No arithmetic is performed. Samples pass through bit-exact and zeros are all-zero words.
- Reset (asserted at any time, including mid-row):
  - `D`=0, window=0, `cnt`=0, state FILL.
  - `s_ready`=0 while reset is asserted.
  - `d_valid`, `d_first`, `d_last`, `row_drop` = 0; `d_nvalid`=0.
  - A partial row is lost and no tile is emitted for it.

## Timing
- Normal tile: the edge that accepts the completing sample also loads `D`. `d_valid` and the sidebands are high for the following cycle only.
- Padded tail: the edge accepting the `s_last` sample enters FLUSH. `s_ready` is low for that one cycle. The next edge loads `D` and asserts `d_valid` (or `row_drop`) for one cycle.
- `s_ready` is combinational: high in FILL and RUN after reset release, low in FLUSH and during reset.
- Throughput is one sample per cycle. Tiles are at least 5 cycles apart within a row, except a FLUSH tile, which can follow a full tile after 2 cycles.
- `D` is held stable until the next emission, so `wc` sees a stable input for its pipeline.

## Test plan
- Row [2,-10,3,4,-13,-18,-16,-28] with `s_last` on the 8th sample:
  - One tile, `D`=80'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000_1111100100.
  - `d_first`=`d_last`=1, `d_nvalid`=5.
  - `wc` output `Z` equals [62,-42,-223,-242,-41].
- Row 1..13, `s_valid` continuous:
  - Tile [1..8] with `d_first`, then tile [6..13] with `d_last`, `d_nvalid`=5.
  - `s_ready` never drops.
- Row 1..10:
  - Tile [1..8], then after one `s_ready`-low cycle, tile [6,7,8,9,10,0,0,0] with `d_last`, `d_nvalid`=2.
- Short rows:
  - Row 1..5 gives tile [1,2,3,4,5,0,0,0] with `d_first`=`d_last`=1, `d_nvalid`=2.
  - Row [7,8,9] gives a `row_drop` pulse, no `d_valid`, `D` unchanged.
- Source holds `s_valid`=1 with the next row's first sample during FLUSH:
  - Not accepted during the FLUSH cycle; accepted on the next cycle as the first sample of the new row.
- `s_valid` toggled 1/0, then `rst` low after sample 6 of a row:
  - Immediately `D`=0, `d_valid`=0, `s_ready`=0.
  - After release, a fresh 8-sample row yields a correct first tile with `d_first`=1.

Source files
------------

// File: rtl/wino_tile_feeder_if.sv
// Stream-in / tile-out bundle between the sample source, wino_tile_feeder and the wc core.
// master = sample source and tile consumer; slave = the feeder itself.
interface wino_tile_feeder_if #(
   parameter int DW   = 10,
   parameter int TILE = 8
);
   logic                 s_valid;
   logic                 s_ready;
   logic [DW-1:0]        s_data;
   logic                 s_last;
   logic [TILE*DW-1:0]   D;
   logic                 d_valid;
   logic                 d_first;
   logic                 d_last;
   logic [2:0]           d_nvalid;
   logic                 row_drop;

   modport master (
      output s_valid, s_data, s_last,
      input  s_ready, D, d_valid, d_first, d_last, d_nvalid, row_drop
   );

   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready, D, d_valid, d_first, d_last, d_nvalid, row_drop
   );
endinterface

// File: rtl/wino_tile_feeder.sv
// Builds overlapping 8-sample tiles (stride 5, overlap 3) from a serial sample row for the
// Winograd F(5,4) core; short row tails are zero-padded, rows of 3 or fewer samples are dropped.
module wino_tile_feeder #(
   parameter int DW   = 10,
   parameter int TILE = 8,
   parameter int STEP = 5
) (
   input  logic              clk,
   input  logic              rst,
   wino_tile_feeder_if.slave bus
);
   localparam logic [3:0] TILE_W    = 4'(TILE);
   localparam logic [3:0] STEP_W    = 4'(STEP);
   localparam logic [3:0] OVERLAP_W = 4'(TILE - STEP);

   typedef enum logic [1:0] {FILL, RUN, FLUSH} state_e;

   state_e               state_q;
   logic [3:0]           cnt_q;
   logic                 from_run_q;
   logic [TILE*DW-1:0]   win_q;
   logic [TILE*DW-1:0]   d_q;
   logic                 d_valid_q;
   logic                 d_first_q;
   logic                 d_last_q;
   logic [2:0]           d_nvalid_q;
   logic                 row_drop_q;

   logic [TILE*DW-1:0]   shift_d;
   logic [TILE*DW-1:0]   pad_d;
   logic [3:0]           pad_n;
   logic                 accept;

   assign bus.s_ready = rst && (state_q != FLUSH);
   assign accept      = bus.s_valid && bus.s_ready;

   always_comb begin
      // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
      shift_d = {win_q[(TILE-1)*DW-1:0], bus.s_data};
      pad_n   = from_run_q ? (STEP_W - cnt_q) : (TILE_W - cnt_q);
      pad_d   = win_q << (pad_n * DW);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the window is a flop array, not a RAM, so it is cleared with the rest of the state.
         state_q    <= FILL;
         cnt_q      <= '0;
         from_run_q <= 1'b0;
         win_q      <= '0;
         d_q        <= '0;
         d_valid_q  <= 1'b0;
         d_first_q  <= 1'b0;
         d_last_q   <= 1'b0;
         d_nvalid_q <= '0;
         row_drop_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
         d_valid_q  <= 1'b0;
         d_first_q  <= 1'b0;
         d_last_q   <= 1'b0;
         row_drop_q <= 1'b0;

         unique case (state_q)
            FILL: if (accept) begin
               win_q <= shift_d;
               if (cnt_q == TILE_W - 4'd1) begin
                  d_q        <= shift_d;
                  d_valid_q  <= 1'b1;
                  d_first_q  <= 1'b1;
                  d_last_q   <= bus.s_last;
                  d_nvalid_q <= 3'(STEP_W);
                  cnt_q      <= '0;
                  state_q    <= bus.s_last ? FILL : RUN;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
                  if (bus.s_last) begin
                     from_run_q <= 1'b0;
                     state_q    <= FLUSH;
                  end
               end
            end

            RUN: if (accept) begin
               win_q <= shift_d;
               if (cnt_q == STEP_W - 4'd1) begin
                  d_q        <= shift_d;
                  d_valid_q  <= 1'b1;
                  d_last_q   <= bus.s_last;
                  d_nvalid_q <= 3'(STEP_W);
                  cnt_q      <= '0;
                  state_q    <= bus.s_last ? FILL : RUN;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
                  if (bus.s_last) begin
                     from_run_q <= 1'b1;
                     state_q    <= FLUSH;
                  end
               end
            end

            FLUSH: begin
               cnt_q   <= '0;
               state_q <= FILL;
               // A first tile with no sample beyond the overlap yields no meaningful output.
               if (!from_run_q && cnt_q <= OVERLAP_W) begin
                  row_drop_q <= 1'b1;
               end else begin
                  win_q      <= pad_d;
                  d_q        <= pad_d;
                  d_valid_q  <= 1'b1;
                  d_first_q  <= !from_run_q;
                  d_last_q   <= 1'b1;
                  d_nvalid_q <= from_run_q ? 3'(cnt_q) : 3'(cnt_q - OVERLAP_W);
               end
            end

            default: state_q <= FILL;
         endcase
      end
   end

   assign bus.D        = d_q;
   assign bus.d_valid  = d_valid_q;
   assign bus.d_first  = d_first_q;
   assign bus.d_last   = d_last_q;
   assign bus.d_nvalid = d_nvalid_q;
   assign bus.row_drop = row_drop_q;
endmodule
